// File: rtl/instr_encode.sv
// RV32 instruction-field encoder with immediate legality checks, feeding an
// instruction-memory writer through a single valid/ready output register.
module instr_encode #(
    parameter  int ADDR_W             = 10,
    localparam int ARCH               = 32,
    localparam int REGFILE_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [6:0]                    op_code_in,
    input  logic [2:0]                    func3_in,
    input  logic [6:0]                    func7_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rs1_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rs2_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_in,
    input  logic [ARCH-1:0]               imm_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [ARCH-1:0]               instr_out,
    output logic [ADDR_W-1:0]             addr_out,
    output logic                          err_out,
    output logic [1:0]                    err_code_out,
    output logic [15:0]                   instr_count_out,
    output logic [7:0]                    err_count_out
);

    localparam logic [6:0] OP_REG       = 7'b0110011;
    localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
    localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;
    localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;
    localparam logic [6:0] OP_JUMP      = 7'b1101111;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_RANGE  = 2'b10,
        ERR_ALIGN  = 2'b11
    } err_e;

    function automatic logic in_range(input logic signed [ARCH-1:0] v,
                                      input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Encoder datapath
    logic signed [ARCH-1:0] imm_s;
    logic [ARCH-1:0]        word_enc;
    logic                   op_ok;
    logic                   range_ok;
    logic                   align_ok;
    logic                   is_shift;
    err_e                   code_enc;

    assign imm_s    = imm_in;
    assign is_shift = (func3_in == 3'b001) || (func3_in == 3'b101);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
        word_enc = '0;
        op_ok    = 1'b1;
        range_ok = 1'b1;
        align_ok = 1'b1;
        case (op_code_in)
            OP_REG: begin
                word_enc = {func7_in, rs2_in, rs1_in, func3_in, rd_in, op_code_in};
            end
            OP_IMM_ARITH: begin
                if (is_shift) begin
                    word_enc = {func7_in, imm_in[4:0], rs1_in, func3_in, rd_in, op_code_in};
                    range_ok = in_range(imm_s, 0, 31);
                end else begin
                    word_enc = {imm_in[11:0], rs1_in, func3_in, rd_in, op_code_in};
                    range_ok = in_range(imm_s, -2048, 2047);
                end
            end
            OP_IMM_JUMP, OP_IMM_LOAD: begin
                word_enc = {imm_in[11:0], rs1_in, func3_in, rd_in, op_code_in};
                range_ok = in_range(imm_s, -2048, 2047);
            end
            OP_STORE: begin
                word_enc = {imm_in[11:5], rs2_in, rs1_in, func3_in, imm_in[4:0], op_code_in};
                range_ok = in_range(imm_s, -2048, 2047);
            end
            OP_BRANCH: begin
                word_enc = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, func3_in,
                            imm_in[4:1], imm_in[11], op_code_in};
                range_ok = in_range(imm_s, -4096, 4095);
                align_ok = !imm_in[0];
            end
            OP_U_L_LOAD: begin
                word_enc = {imm_in[31:12], rd_in, op_code_in};
                range_ok = (imm_in[11:0] == 12'h000);
            end
            OP_JUMP: begin
                word_enc = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, op_code_in};
                range_ok = in_range(imm_s, -1048576, 1048575);
                align_ok = !imm_in[0];
            end
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    // Error priority: opcode over range over alignment
    always_comb begin
        if (!op_ok)         code_enc = ERR_OPCODE;
        else if (!range_ok) code_enc = ERR_RANGE;
        else if (!align_ok) code_enc = ERR_ALIGN;
        else                code_enc = ERR_NONE;
    end

    // Output register and bookkeeping
    logic              valid_q,       valid_d;
    logic [ARCH-1:0]   instr_q,       instr_d;
    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [ADDR_W-1:0] next_addr_q,   next_addr_d;
    logic [15:0]       instr_count_q, instr_count_d;
    logic [7:0]        err_count_q,   err_count_d;
    logic              err_q,         err_d;
    err_e              err_code_q,    err_code_d;
    logic              in_hs;
    logic              out_hs;

    assign ready_out = !rst && !clear_in && (!valid_q || ready_in);
    assign in_hs     = valid_in && ready_out;
    assign out_hs    = valid_q && ready_in;

    always_comb begin
        valid_d       = valid_q;
        instr_d       = instr_q;
        addr_d        = addr_q;
        next_addr_d   = next_addr_q;
        instr_count_d = instr_count_q;
        err_count_d   = err_count_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        if (clear_in) begin
            valid_d       = 1'b0;
            next_addr_d   = '0;
            instr_count_d = '0;
            err_count_d   = '0;
            err_d         = 1'b0;
            err_code_d    = ERR_NONE;
        end else begin
            if (out_hs) begin
                valid_d = 1'b0;
                if (instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
            end
            if (in_hs) begin
                if (code_enc == ERR_NONE) begin
                    valid_d     = 1'b1;
                    instr_d     = word_enc;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_W'(4);
                end else begin
                    err_d      = 1'b1;
                    err_code_d = code_enc;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so each flop samples the pre-edge value of every other.
        if (rst) begin
            valid_q       <= 1'b0;
            instr_q       <= '0;
            addr_q        <= '0;
            next_addr_q   <= '0;
            instr_count_q <= '0;
            err_count_q   <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            addr_q        <= addr_d;
            next_addr_q   <= next_addr_d;
            instr_count_q <= instr_count_d;
            err_count_q   <= err_count_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign valid_out       = valid_q;
    assign instr_out       = instr_q;
    assign addr_out        = addr_q;
    assign err_out         = err_q;
    assign err_code_out    = err_code_q;
    assign instr_count_out = instr_count_q;
    assign err_count_out   = err_count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Self-checking bench for instr_encode: hand-computed vector table, corner
// sequences and randomized traffic against a decode-based transaction model.
module tb_instr_encode;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst, clear_in, valid_in, ready_in;
    logic [6:0]  op_code_in, func7_in;
    logic [2:0]  func3_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic [31:0] imm_in;

    logic              ready_out, valid_out, err_out;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] addr_out;
    logic [1:0]        err_code_out;
    logic [15:0]       instr_count_out;
    logic [7:0]        err_count_out;

    logic        d4_ready_out, d4_valid_out, d4_err_out;
    logic [31:0] d4_instr_out;
    logic [3:0]  d4_addr_out;
    logic [1:0]  d4_err_code_out;
    logic [15:0] d4_instr_count_out;
    logic [7:0]  d4_err_count_out;

    always #5 clk = ~clk;

    instr_encode #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clear_in(clear_in), .valid_in(valid_in), .ready_out(ready_out),
        .op_code_in(op_code_in), .func3_in(func3_in), .func7_in(func7_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in),
        .valid_out(valid_out), .ready_in(ready_in), .instr_out(instr_out), .addr_out(addr_out),
        .err_out(err_out), .err_code_out(err_code_out),
        .instr_count_out(instr_count_out), .err_count_out(err_count_out)
    );

    instr_encode #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear_in(clear_in), .valid_in(valid_in), .ready_out(d4_ready_out),
        .op_code_in(op_code_in), .func3_in(func3_in), .func7_in(func7_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in),
        .valid_out(d4_valid_out), .ready_in(ready_in), .instr_out(d4_instr_out), .addr_out(d4_addr_out),
        .err_out(d4_err_out), .err_code_out(d4_err_code_out),
        .instr_count_out(d4_instr_count_out), .err_count_out(d4_err_count_out)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic [31:0] word;
        logic [1:0]  code;
        logic [9:0]  addr;
    } vec_t;

    typedef struct {
        bundle_t           b;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    // Format-independent view of an instruction: signed immediate plus the
    // register/func/opcode fields packed as {f7, rs2, rs1, f3, rd, op}.
    typedef struct {
        int          imm;
        logic [31:0] regs;
    } view_t;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    int          m_next_addr = 0;
    int          m_icnt = 0;
    int          m_ecnt = 0;
    logic        m_err = 1'b0;
    logic [1:0]  m_code = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_code(input bundle_t b);
        int v, lo, hi;
        logic even;
        v    = $signed(b.imm);
        even = 1'b0;
        case (b.op)
            7'h33: return 2'd0;
            7'h13: begin
                if (b.f3 == 3'd1 || b.f3 == 3'd5) begin lo = 0; hi = 31; end
                else begin lo = -2048; hi = 2047; end
            end
            7'h67, 7'h03, 7'h23: begin lo = -2048; hi = 2047; end
            7'h63: begin lo = -4096; hi = 4095; even = 1'b1; end
            7'h6F: begin lo = -1048576; hi = 1048575; even = 1'b1; end
            7'h37: return (b.imm % 4096 != 0) ? 2'd2 : 2'd0;
            default: return 2'd1;
        endcase
        if (v < lo || v > hi) return 2'd2;
        if (even && (v % 2 != 0)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic view_t project(input bundle_t b);
        view_t r;
        r.imm  = $signed(b.imm);
        r.regs = {25'd0, b.op};
        case (b.op)
            7'h33: begin r.imm = 0; r.regs = {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op}; end
            7'h13: begin
                if (b.f3 == 3'd1 || b.f3 == 3'd5) r.regs = {b.f7, 5'd0, b.rs1, b.f3, b.rd, b.op};
                else                              r.regs = {7'd0, 5'd0, b.rs1, b.f3, b.rd, b.op};
            end
            7'h67, 7'h03: r.regs = {7'd0, 5'd0, b.rs1, b.f3, b.rd, b.op};
            7'h23, 7'h63: r.regs = {7'd0, b.rs2, b.rs1, b.f3, 5'd0, b.op};
            7'h37, 7'h6F: r.regs = {7'd0, 5'd0, 5'd0, 3'd0, b.rd, b.op};
            default: r.imm = 0;
        endcase
        return r;
    endfunction

    // Standard RV32 decode of a word back into the same view.
    function automatic view_t decode(input logic [31:0] w);
        view_t r;
        int t;
        r.imm  = 0;
        r.regs = {25'd0, w[6:0]};
        case (w[6:0])
            7'h33: r.regs = w;
            7'h13: begin
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    r.imm  = int'(w[24:20]);
                    r.regs = {w[31:25], 5'd0, w[19:7], w[6:0]};
                end else begin
                    t = $signed({w[31:20], 20'h0}); r.imm = t >>> 20;
                    r.regs = {12'd0, w[19:0]};
                end
            end
            7'h67, 7'h03: begin
                t = $signed({w[31:20], 20'h0}); r.imm = t >>> 20;
                r.regs = {12'd0, w[19:0]};
            end
            7'h23: begin
                t = $signed({w[31:25], w[11:7], 20'h0}); r.imm = t >>> 20;
                r.regs = {7'd0, w[24:12], 5'd0, w[6:0]};
            end
            7'h63: begin
                t = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'h0}); r.imm = t >>> 19;
                r.regs = {7'd0, w[24:12], 5'd0, w[6:0]};
            end
            7'h37: begin
                r.imm  = $signed({w[31:12], 12'h0});
                r.regs = {20'd0, w[11:0]};
            end
            7'h6F: begin
                t = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'h0}); r.imm = t >>> 11;
                r.regs = {20'd0, w[11:0]};
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic bundle_t cur_bundle();
        bundle_t b;
        b.op = op_code_in; b.f3 = func3_in; b.f7 = func7_in;
        b.rs1 = rs1_in; b.rs2 = rs2_in; b.rd = rd_in; b.imm = imm_in;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        op_code_in = b.op; func3_in = b.f3; func7_in = b.f7;
        rs1_in = b.rs1; rs2_in = b.rs2; rd_in = b.rd; imm_in = b.imm;
    endtask

    // One clock: predict ready_out, advance the model through the edge, then
    // compare every output with the model just after the edge.
    task automatic tick();
        logic    exp_ready, was_rst;
        bundle_t cur;
        logic [1:0] c;
        exp_t    e;
        view_t   got, want;
        #1;
        exp_ready = !rst && !clear_in && (exp_q.size() == 0 || ready_in);
        check("ready_out", ready_out, exp_ready);
        was_rst = rst;
        if (rst || clear_in) begin
            exp_q.delete();
            m_next_addr = 0; m_icnt = 0; m_ecnt = 0; m_err = 1'b0; m_code = 2'b00;
        end else begin
            if (exp_q.size() != 0 && ready_in) begin
                void'(exp_q.pop_front());
                if (m_icnt < 65535) m_icnt++;
            end
            if (valid_in && exp_ready) begin
                cur = cur_bundle();
                c   = ref_code(cur);
                if (c != 2'd0) begin
                    m_err = 1'b1; m_code = c;
                    if (m_ecnt < 255) m_ecnt++;
                end else begin
                    e.b = cur; e.addr = ADDR_W'(m_next_addr);
                    exp_q.push_back(e);
                    m_next_addr = (m_next_addr + 4) % (1 << ADDR_W);
                end
            end
        end
        @(posedge clk);
        #1;
        check("valid_out", valid_out, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            got  = decode(instr_out);
            want = project(exp_q[0].b);
            check("instr.imm", got.imm, want.imm);
            check("instr.fields", got.regs, want.regs);
            check("addr_out", addr_out, exp_q[0].addr);
        end
        if (was_rst) begin
            check("rst.instr_out", instr_out, 32'h0);
            check("rst.addr_out", addr_out, '0);
        end
        check("instr_count", instr_count_out, m_icnt);
        check("err_count", err_count_out, m_ecnt);
        check("err_out", err_out, m_err);
        check("err_code", err_code_out, m_code);
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [31:0] word,
                                input logic [1:0] code, input logic [9:0] addr);
        vec_t v;
        v.b.op = op; v.b.f3 = f3; v.b.f7 = f7;
        v.b.rs1 = rs1; v.b.rs2 = rs2; v.b.rd = rd; v.b.imm = imm;
        v.word = word; v.code = code; v.addr = addr;
        return v;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        logic [6:0] ops [9];
        int bounds [13];
        ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h00};
        bounds = '{-1048576, 1048575, -4096, 4095, -2048, 2047, 2048, -2049, 0, 31, 32, 4096, 1048576};
        b.op = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 9) == 0) b.op = 7'($urandom);
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.rd = 5'($urandom);
        case ($urandom_range(0, 5))
            0: b.imm = $urandom;
            1: b.imm = 32'($signed(int'($urandom_range(0, 8191)) - 4096));
            2: b.imm = 32'(bounds[$urandom_range(0, 12)]);
            3: b.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
            4: b.imm = $urandom & 32'hFFFF_F000;
            default: b.imm = 32'($urandom_range(0, 31));
        endcase
        return b;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vecs[$];
        bundle_t reg_b;
        int      icnt_at_stall;
        logic [3:0] d4_seq [5];

        vecs.push_back(mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,        32'h002081B3, 2'd0, 10'h000));
        vecs.push_back(mk(7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 32'hFE208CE3, 2'd0, 10'h004));
        vecs.push_back(mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd1, 32'd2048,     32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h13, 3'd0, 7'h00, 5'd6, 5'd0, 5'd5, 32'hFFFFFFFF, 32'hFFF30293, 2'd0, 10'h008));
        vecs.push_back(mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFF800, 32'h80000093, 2'd0, 10'h00C));
        vecs.push_back(mk(7'h13, 3'd1, 7'h00, 5'd2, 5'd0, 5'd1, 32'd31,       32'h01F11093, 2'd0, 10'h010));
        vecs.push_back(mk(7'h13, 3'd5, 7'h20, 5'd4, 5'd0, 5'd3, 32'd5,        32'h40525193, 2'd0, 10'h014));
        vecs.push_back(mk(7'h13, 3'd1, 7'h00, 5'd2, 5'd0, 5'd1, 32'd32,       32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h13, 3'd5, 7'h00, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8,        32'h0020A423, 2'd0, 10'h018));
        vecs.push_back(mk(7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC, 32'hFFC12283, 2'd0, 10'h01C));
        vecs.push_back(mk(7'h67, 3'd0, 7'h00, 5'd5, 5'd0, 5'd1, 32'd0,        32'h000280E7, 2'd0, 10'h020));
        vecs.push_back(mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 32'h12345000, 32'h123453B7, 2'd0, 10'h024));
        vecs.push_back(mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 32'h12345001, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00000800, 32'h001000EF, 2'd0, 10'h028));
        vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF06F, 2'd0, 10'h02C));
        vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00100000, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd3,        32'h0,        2'd3, 10'h000));
        vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00100001, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000FFE, 32'h7E000FE3, 2'd0, 10'h030));
        vecs.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00001000, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd5,        32'h0,        2'd3, 10'h000));
        vecs.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFEFFF, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd9999,     32'h0,        2'd1, 10'h000));
        vecs.push_back(mk(7'h23, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF7FF, 32'h0,        2'd2, 10'h000));
        vecs.push_back(mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'hFFF00000, 32'h8000016F, 2'd0, 10'h034));
        vecs.push_back(mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF000, 32'h80000063, 2'd0, 10'h038));
        vecs.push_back(mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0,        32'h0,        2'd1, 10'h000));

        reg_b = vecs[0].b;
        d4_seq = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};

        // Reset
        rst = 1'b1; clear_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        drive(reg_b);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Vector table, back-to-back with ready_in high
        foreach (vecs[i]) begin
            drive(vecs[i].b);
            valid_in = 1'b1;
            ready_in = 1'b1;
            tick();
            if (vecs[i].code == 2'd0) begin
                check($sformatf("vec%0d.word", i), instr_out, vecs[i].word);
                check($sformatf("vec%0d.addr", i), addr_out, vecs[i].addr);
                check($sformatf("vec%0d.valid", i), valid_out, 1'b1);
            end else begin
                check($sformatf("vec%0d.code", i), err_code_out, vecs[i].code);
                check($sformatf("vec%0d.noval", i), valid_out, 1'b0);
            end
        end
        valid_in = 1'b0;
        tick();

        // Back-pressure: word held for 3 cycles, retires on first ready_in
        drive(reg_b); valid_in = 1'b1; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        icnt_at_stall = m_icnt;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall.ready_out", ready_out, 1'b0);
            check("stall.word", instr_out, 32'h002081B3);
            check("stall.valid", valid_out, 1'b1);
        end
        valid_in = 1'b0; ready_in = 1'b1;
        tick();
        check("stall.retire_count", instr_count_out, icnt_at_stall + 1);
        check("stall.retired", valid_out, 1'b0);

        // rst, then clear_in, arriving while a word is stalled
        for (int k = 0; k < 2; k++) begin
            drive(reg_b); valid_in = 1'b1; ready_in = 1'b1;
            tick();
            ready_in = 1'b0;
            tick();
            if (k == 0) rst = 1'b1; else clear_in = 1'b1;
            tick();
            check("flush.valid", valid_out, 1'b0);
            check("flush.icnt", instr_count_out, 0);
            rst = 1'b0; clear_in = 1'b0; ready_in = 1'b1;
            tick();
            check("flush.first_addr", addr_out, 0);
        end
        valid_in = 1'b0;
        tick();

        // ADDR_W=4 wrap over 5 back-to-back bundles
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        drive(reg_b); valid_in = 1'b1; ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("wrap4.addr%0d", k), d4_addr_out, d4_seq[k]);
            check($sformatf("wrap4.valid%0d", k), d4_valid_out, 1'b1);
        end
        valid_in = 1'b0;
        tick();

        // Error counter saturation
        reg_b.op = 7'h7F;
        drive(reg_b); valid_in = 1'b1;
        for (int k = 0; k < 260; k++) tick();
        check("err_count.sat", err_count_out, 8'd255);
        valid_in = 1'b0;
        tick();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            drive(rand_bundle());
            valid_in = ($urandom_range(0, 9) < 7);
            ready_in = ($urandom_range(0, 9) < 7);
            rst      = ($urandom_range(0, 199) == 0);
            clear_in = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
